// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters. Fetch gets a combinational next-PC prediction for lookupPC. The
//   execute stage trains the table and gets a registered mispredict/redirect
//   result plus a saturating mispredict statistics counter.
//
// Ports
//   clock              in   core clock, all state on the rising edge
//   reset              in   synchronous, active-high; clears valid bits/stats
//   lookupPC           in   PC being fetched this cycle
//   predictTaken       out  BTB hit and direction counter MSB set
//   predictedPC        out  predicted next fetch PC (target or lookupPC+4)
//   resolveValid       in   a control transfer resolved in execute
//   resolvePC          in   PC of the resolved instruction
//   resolveTaken       in   actual direction (1 for jal/jalr)
//   resolveTarget      in   actual taken target
//   resolvePredictedPC in   next PC that fetch used for this instruction
//   mispredict         out  registered one-cycle pulse after a bad resolve
//   redirectPC         out  registered correct next PC, updated on every resolve
//   mispredictCount    out  saturating number of mispredicts since reset
// -----------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int ENTRIES   = 16,
   parameter int CTR_BITS  = 2,
   parameter int STAT_BITS = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [XLEN-1:0]      lookupPC,
   output logic                 predictTaken,
   output logic [XLEN-1:0]      predictedPC,
   input  logic                 resolveValid,
   input  logic [XLEN-1:0]      resolvePC,
   input  logic                 resolveTaken,
   input  logic [XLEN-1:0]      resolveTarget,
   input  logic [XLEN-1:0]      resolvePredictedPC,
   output logic                 mispredict,
   output logic [XLEN-1:0]      redirectPC,
   output logic [STAT_BITS-1:0] mispredictCount
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;

   // Weakly taken is the MSB alone; weakly not-taken is the value just below.
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

   // Table storage. Tags/targets carry no reset: they are meaningless while
   // the matching valid bit is clear.
   logic                r_valid  [ENTRIES];
   logic [TAG_W-1:0]    r_tag    [ENTRIES];
   logic [XLEN-1:0]     r_target [ENTRIES];
   logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

   logic                 r_mispredict;
   logic [XLEN-1:0]      r_redirect;
   logic [STAT_BITS-1:0] r_count;

   // ---------------- lookup (combinational, pre-update contents) -------------
   logic [IDX-1:0]   w_lk_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic             w_lk_hit;

   assign w_lk_idx = lookupPC[IDX+1:2];
   assign w_lk_tag = lookupPC[XLEN-1:IDX+2];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

   assign predictTaken = w_lk_hit && r_ctr[w_lk_idx][CTR_BITS-1];
   assign predictedPC  = predictTaken ? r_target[w_lk_idx] : lookupPC + XLEN'(4);

   // ---------------- resolve -------------------------------------------------
   logic [IDX-1:0]   w_rs_idx;
   logic [TAG_W-1:0] w_rs_tag;
   logic             w_rs_hit;
   logic [XLEN-1:0]  w_actual_pc;
   logic             w_mispredict_next;

   assign w_rs_idx          = resolvePC[IDX+1:2];
   assign w_rs_tag          = resolvePC[XLEN-1:IDX+2];
   assign w_rs_hit          = r_valid[w_rs_idx] && (r_tag[w_rs_idx] == w_rs_tag);
   assign w_actual_pc       = resolveTaken ? resolveTarget : resolvePC + XLEN'(4);
   assign w_mispredict_next = resolveValid && (w_actual_pc != resolvePredictedPC);

   // Valid bits, counters and result registers. Reset wins over any
   // simultaneous resolve, so in-flight training and pulses are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mispredict <= 1'b0;
         r_redirect   <= '0;
         r_count      <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= CTR_WNT;
         end
      end else begin
         r_mispredict <= w_mispredict_next;
         if (resolveValid) begin
            r_redirect <= w_actual_pc;
         end
         // Counted on the same edge that registers the pulse; never wraps.
         if (w_mispredict_next && (r_count != '1)) begin
            r_count <= r_count + STAT_BITS'(1);
         end
         if (resolveValid) begin
            if (w_rs_hit) begin
               if (resolveTaken) begin
                  if (r_ctr[w_rs_idx] != CTR_MAX) begin
                     r_ctr[w_rs_idx] <= r_ctr[w_rs_idx] + CTR_BITS'(1);
                  end
               end else if (r_ctr[w_rs_idx] != CTR_MIN) begin
                  r_ctr[w_rs_idx] <= r_ctr[w_rs_idx] - CTR_BITS'(1);
               end
            end else if (resolveTaken) begin
               // Allocate or replace the aliasing entry, starting weakly taken.
               r_valid[w_rs_idx] <= 1'b1;
               r_ctr[w_rs_idx]   <= CTR_WT;
            end
         end
      end
   end

   // Tag/target payload. Any taken resolve (hit or allocate) writes the
   // target; the tag only changes on allocation.
   always_ff @(posedge clock) begin
      if (!reset && resolveValid && resolveTaken) begin
         r_target[w_rs_idx] <= resolveTarget;
         if (!w_rs_hit) begin
            r_tag[w_rs_idx] <= w_rs_tag;
         end
      end
   end

   assign mispredict      = r_mispredict;
   assign redirectPC      = r_redirect;
   assign mispredictCount = r_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] lookupPC = 32'h0;
   logic        resolveValid = 1'b0;
   logic [31:0] resolvePC = 32'h0;
   logic        resolveTaken = 1'b0;
   logic [31:0] resolveTarget = 32'h0;
   logic [31:0] resolvePredictedPC = 32'h0;

   logic        predictTaken, predictTaken2;
   logic [31:0] predictedPC, predictedPC2;
   logic        mispredict, mispredict2;
   logic [31:0] redirectPC, redirectPC2;
   logic [15:0] mispredictCount;
   logic [1:0]  mispredictCount2;

   always #5 clock = ~clock;

   branch_predict_unit dut (
      .clock(clock), .reset(reset), .lookupPC(lookupPC),
      .predictTaken(predictTaken), .predictedPC(predictedPC),
      .resolveValid(resolveValid), .resolvePC(resolvePC),
      .resolveTaken(resolveTaken), .resolveTarget(resolveTarget),
      .resolvePredictedPC(resolvePredictedPC),
      .mispredict(mispredict), .redirectPC(redirectPC),
      .mispredictCount(mispredictCount)
   );

   // Same stimulus, narrow statistics counter to exercise saturation.
   branch_predict_unit #(.STAT_BITS(2)) dut_s2 (
      .clock(clock), .reset(reset), .lookupPC(lookupPC),
      .predictTaken(predictTaken2), .predictedPC(predictedPC2),
      .resolveValid(resolveValid), .resolvePC(resolvePC),
      .resolveTaken(resolveTaken), .resolveTarget(resolveTarget),
      .resolvePredictedPC(resolvePredictedPC),
      .mispredict(mispredict2), .redirectPC(redirectPC2),
      .mispredictCount(mispredictCount2)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: 16 entries, 2-bit counters held as plain integers 0..3.
   bit          m_valid [16];
   longint      m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic        e_mis;
   logic [31:0] e_redir;
   int          e_cnt, e_cnt2;

   function automatic int m_index(logic [31:0] pc);
      return int'((longint'(pc) / 4) % 16);
   endfunction

   function automatic longint m_tagof(logic [31:0] pc);
      return longint'(pc) / 64;
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
   endfunction

   function automatic bit m_ptaken(logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_ppc(logic [31:0] pc);
      logic [31:0] nxt;
      nxt = pc + 32'd4;
      return m_ptaken(pc) ? m_tgt[m_index(pc)] : nxt;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      e_mis = 1'b0; e_redir = 32'h0; e_cnt = 0; e_cnt2 = 0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: check lookup outputs against the pre-update model, advance
   // the model by the spec rules, then check the registered outputs.
   task automatic cycle();
      logic [31:0] actual;
      int          i;
      #1;
      chk("predictTaken", {31'b0, predictTaken}, {31'b0, m_ptaken(lookupPC)});
      chk("predictedPC", predictedPC, m_ppc(lookupPC));
      if (reset) begin
         m_reset();
      end else begin
         e_mis = 1'b0;
         if (resolveValid) begin
            actual  = resolveTaken ? resolveTarget : resolvePC + 32'd4;
            e_mis   = (actual != resolvePredictedPC);
            e_redir = actual;
            i = m_index(resolvePC);
            if (m_hit(resolvePC)) begin
               if (resolveTaken) begin
                  m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                  m_tgt[i] = resolveTarget;
               end else begin
                  m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
               end
            end else if (resolveTaken) begin
               m_valid[i] = 1'b1;
               m_tag[i]   = m_tagof(resolvePC);
               m_tgt[i]   = resolveTarget;
               m_ctr[i]   = 2;
            end
         end
         if (e_mis) begin
            if (e_cnt < 65535) e_cnt++;
            if (e_cnt2 < 3) e_cnt2++;
         end
      end
      @(posedge clock);
      #1;
      chk("mispredict", {31'b0, mispredict}, {31'b0, e_mis});
      chk("redirectPC", redirectPC, e_redir);
      chk("mispredictCount", {16'b0, mispredictCount}, e_cnt);
      chk("mispredictCount_s2", {30'b0, mispredictCount2}, e_cnt2);
      $display("t=%0t rst=%0d lk=%08h pt=%0d ppc=%08h rv=%0d rpc=%08h tk=%0d tgt=%08h rpp=%08h mis=%0d redir=%08h cnt=%0d",
               $time, reset, lookupPC, predictTaken, predictedPC, resolveValid, resolvePC,
               resolveTaken, resolveTarget, resolvePredictedPC, mispredict, redirectPC,
               mispredictCount);
   endtask

   task automatic step(logic rst, logic [31:0] lpc, logic rv, logic [31:0] rpc,
                       logic rt, logic [31:0] rtgt, logic [31:0] rpp);
      reset = rst; lookupPC = lpc; resolveValid = rv; resolvePC = rpc;
      resolveTaken = rt; resolveTarget = rtgt; resolvePredictedPC = rpp;
      cycle();
   endtask

   task automatic peek(logic [31:0] lpc, logic exp_pt, logic [31:0] exp_ppc, string tag);
      resolveValid = 1'b0; reset = 1'b0; lookupPC = lpc;
      #1;
      chk({tag, "_pt"}, {31'b0, predictTaken}, {31'b0, exp_pt});
      chk({tag, "_ppc"}, predictedPC, exp_ppc);
   endtask

   initial begin
      logic [31:0] rpc, lpc, tgt, rpp;
      // Bring the design out of the unknown power-up state.
      @(posedge clock); #1;
      m_reset();

      // 1: reset state
      step(1'b1, 32'h100, 1'b0, 0, 1'b0, 0, 0);
      peek(32'h100, 1'b0, 32'h104, "t1");
      chk("t1_mis", {31'b0, mispredict}, 32'h0);
      chk("t1_cnt", {16'b0, mispredictCount}, 32'h0);

      // 2: first taken resolve allocates and mispredicts
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 32'h104);
      chk("t2_mis", {31'b0, mispredict}, 32'h1);
      chk("t2_redir", redirectPC, 32'h40);
      peek(32'h100, 1'b1, 32'h40, "t2");
      step(1'b0, 32'h100, 1'b0, 0, 1'b0, 0, 0);
      chk("t2_mis_clear", {31'b0, mispredict}, 32'h0);

      // 3: counter walks down to strongly not-taken and back up
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 32'h40);
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 32'h104);
      peek(32'h100, 1'b0, 32'h104, "t3_nt");
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 32'h104);
      peek(32'h100, 1'b0, 32'h104, "t3_one");
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 32'h104);
      peek(32'h100, 1'b1, 32'h40, "t3_tk");

      // 4: alias at same index replaces the entry
      step(1'b0, 32'h140, 1'b1, 32'h140, 1'b1, 32'h80, 32'h144);
      peek(32'h100, 1'b0, 32'h104, "t4_old");
      peek(32'h140, 1'b1, 32'h80, "t4_new");

      // 5: PC wrap
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 0, 1'b0, 0, 0);
      peek(32'hFFFF_FFFC, 1'b0, 32'h0, "t5");
      step(1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      chk("t5_mis", {31'b0, mispredict}, 32'h0);
      chk("t5_redir", redirectPC, 32'h0);

      // 6: reset beats a mispredicting resolve; then counter saturation
      step(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 32'h204);
      chk("t6_mis", {31'b0, mispredict}, 32'h0);
      chk("t6_cnt", {16'b0, mispredictCount}, 32'h0);
      peek(32'h200, 1'b0, 32'h204, "t6_miss");
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 32'h204);
      end
      chk("t6_cnt16", {16'b0, mispredictCount}, 32'd4);
      chk("t6_cnt2_sat", {30'b0, mispredictCount2}, 32'd3);
      step(1'b0, 32'h200, 1'b0, 0, 1'b0, 0, 0);

      // Randomized traffic over a small, aliasing PC pool.
      for (int n = 0; n < 400; n++) begin
         rpc = ($urandom_range(0, 9) == 9) ? 32'hFFFF_FFFC
             : 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'(64 * $urandom_range(0, 2));
         lpc = ($urandom_range(0, 1) == 1) ? rpc
             : 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'(64 * $urandom_range(0, 2));
         tgt = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0) tgt = 32'h2000;
         case ($urandom_range(0, 3))
            0, 1: rpp = m_ppc(rpc);
            2:    rpp = rpc + 32'd4;
            default: rpp = tgt;
         endcase
         step(($urandom_range(0, 49) == 0), lpc, ($urandom_range(0, 3) != 0), rpc,
              $urandom_range(0, 1) == 1, tgt, rpp);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
